// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x5 calculator keypad scanner.
// Key index is row*5+col; key_decode maps an index to its output strobes.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 5;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } key_state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [4:0] K_1     = 5'd0;
  localparam logic [4:0] K_2     = 5'd1;
  localparam logic [4:0] K_3     = 5'd2;
  localparam logic [4:0] K_ADD   = 5'd3;
  localparam logic [4:0] K_BKSP  = 5'd4;
  localparam logic [4:0] K_4     = 5'd5;
  localparam logic [4:0] K_5     = 5'd6;
  localparam logic [4:0] K_6     = 5'd7;
  localparam logic [4:0] K_MUL   = 5'd8;
  localparam logic [4:0] K_CLR   = 5'd9;
  localparam logic [4:0] K_7     = 5'd10;
  localparam logic [4:0] K_8     = 5'd11;
  localparam logic [4:0] K_9     = 5'd12;
  localparam logic [4:0] K_MINUS = 5'd13;
  localparam logic [4:0] K_MC    = 5'd14;
  localparam logic [4:0] K_0     = 5'd15;
  localparam logic [4:0] K_MS    = 5'd16;
  localparam logic [4:0] K_MR    = 5'd17;
  localparam logic [4:0] K_DIV   = 5'd18;
  localparam logic [4:0] K_EQ    = 5'd19;

  typedef struct packed {
    logic       dig;
    logic [3:0] digit;
    logic       op;
    logic [1:0] op_code;
    logic       sub;
    logic       ex;
    logic       bksp;
    logic       clr;
    logic       ms;
    logic       mr;
    logic       mc;
  } key_event_t;

  function automatic logic [4:0] lowest_key(
    input logic [NUM_KEYS-1:0] v
  );
    logic [4:0] k;
    k = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (v[i]) k = 5'(i);
    return k;
  endfunction

  function automatic key_event_t key_decode(
    input logic [4:0] k
  );
    key_event_t e;
    e = '0;
    case (k)
      K_1:     begin e.dig = 1'b1; e.digit = 4'd1; end
      K_2:     begin e.dig = 1'b1; e.digit = 4'd2; end
      K_3:     begin e.dig = 1'b1; e.digit = 4'd3; end
      K_4:     begin e.dig = 1'b1; e.digit = 4'd4; end
      K_5:     begin e.dig = 1'b1; e.digit = 4'd5; end
      K_6:     begin e.dig = 1'b1; e.digit = 4'd6; end
      K_7:     begin e.dig = 1'b1; e.digit = 4'd7; end
      K_8:     begin e.dig = 1'b1; e.digit = 4'd8; end
      K_9:     begin e.dig = 1'b1; e.digit = 4'd9; end
      K_0:     begin e.dig = 1'b1; e.digit = 4'd0; end
      K_ADD:   begin e.op = 1'b1; e.op_code = OP_ADD; end
      K_MUL:   begin e.op = 1'b1; e.op_code = OP_MUL; end
      K_DIV:   begin e.op = 1'b1; e.op_code = OP_DIV; end
      K_MINUS: begin
        e.op = 1'b1;
        e.sub = 1'b1;
        e.op_code = OP_SUB;
      end
      K_BKSP:  e.bksp = 1'b1;
      K_CLR:   e.clr = 1'b1;
      K_MS:    e.ms = 1'b1;
      K_MR:    e.mr = 1'b1;
      K_MC:    e.mc = 1'b1;
      K_EQ:    e.ex = 1'b1;
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/keypad_colscan.sv
// Column driver, row synchronizer and raw key matrix sampler.
// keys holds the latest sample of every key; scan_done pulses after col 4.
module keypad_colscan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_n,
  output logic [NUM_KEYS-1:0] keys,
  output logic                scan_done
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [NUM_ROWS-1:0] row_meta;
  logic [NUM_ROWS-1:0] row_sync;
  logic [DW-1:0]       div_cnt;
  logic [2:0]          col;
  logic                slot_end;

  assign slot_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_meta  <= '1;
      row_sync  <= '1;
      div_cnt   <= '0;
      col       <= '0;
      col_n     <= 5'b11110;
      keys      <= '0;
      scan_done <= 1'b0;
    end else begin
      row_meta  <= row_n;
      row_sync  <= row_meta;
      scan_done <= slot_end && (col == 3'd4);
      if (slot_end) begin
        div_cnt <= '0;
        for (int r = 0; r < NUM_ROWS; r++)
          keys[r*NUM_COLS + int'(col)] <= ~row_sync[r];
        if (col == 3'd4) begin
          col   <= '0;
          col_n <= 5'b11110;
        end else begin
          col   <= col + 3'd1;
          col_n <= {col_n[3:0], 1'b1};
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Debounced 4x5 keypad scanner producing one-cycle key strobes.
// Define KEYPAD_REPEAT_EN for auto-repeat of a held backspace key.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_RATE    = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [4:0] col_n,
  output logic       dig_in,
  output logic [3:0] digit,
  output logic       op_in,
  output logic [1:0] op_code,
  output logic       sub_in,
  output logic       ex_in,
  output logic       bksp_in,
  output logic       reset_in,
  output logic       MS_in,
  output logic       MR_in,
  output logic       MC_in
);

  localparam int DBW = $clog2(DEBOUNCE_SCANS + 1);

  logic [NUM_KEYS-1:0] keys;
  logic                scan_done;
  key_state_t          state;
  logic [4:0]          cand;
  logic [DBW-1:0]      db_cnt;
  logic [NUM_KEYS-1:0] stale;
  logic [NUM_KEYS-1:0] eligible;
  logic [NUM_KEYS-1:0] cand_mask;
  logic                cand_down;
  key_event_t          ev;

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);
  logic [RW-1:0] rep_cnt;
  logic          rep_armed;
  logic          rep_fire;
  assign rep_fire = rep_armed ?
                    (rep_cnt == RW'(REPEAT_RATE - 1)) :
                    (rep_cnt == RW'(REPEAT_DELAY - 1));
`endif

  keypad_colscan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_colscan (
    .clock    (clock),
    .reset    (reset),
    .row_n    (row_n),
    .col_n    (col_n),
    .keys     (keys),
    .scan_done(scan_done)
  );

  // Keys still down from a previous press must be released before they count
  assign eligible  = keys & ~stale;
  assign cand_mask = NUM_KEYS'(1) << cand;
  assign cand_down = keys[cand];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cand   <= '0;
      db_cnt <= '0;
      stale  <= '0;
      ev     <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
`endif
    end else begin
      ev <= '0;
      if (scan_done) begin
        unique case (state)
          IDLE: begin
            stale <= stale & keys;
            if (|eligible) begin
              cand   <= lowest_key(eligible);
              db_cnt <= DBW'(1);
              state  <= PRESS_DB;
            end
          end
          PRESS_DB: begin
            stale <= stale & keys;
            if (!cand_down) begin
              db_cnt <= '0;
              state  <= IDLE;
            end else if (db_cnt >= DBW'(DEBOUNCE_SCANS - 1)) begin
              db_cnt <= '0;
              state  <= HELD;
              ev     <= key_decode(cand);
`ifdef KEYPAD_REPEAT_EN
              rep_cnt   <= '0;
              rep_armed <= 1'b0;
`endif
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end
          HELD: begin
            stale <= keys & ~cand_mask;
            if (!cand_down) begin
              db_cnt <= DBW'(1);
              state  <= REL_DB;
            end
`ifdef KEYPAD_REPEAT_EN
            else if (cand == K_BKSP) begin
              if (rep_fire) begin
                rep_cnt   <= '0;
                rep_armed <= 1'b1;
                ev        <= key_decode(cand);
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
            end
`else
            else begin
              db_cnt <= '0;
            end
`endif
          end
          REL_DB: begin
            stale <= keys & ~cand_mask;
            if (cand_down) begin
              db_cnt <= '0;
              state  <= HELD;
            end else if (db_cnt >= DBW'(DEBOUNCE_SCANS - 1)) begin
              db_cnt <= '0;
              state  <= IDLE;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign dig_in   = ev.dig;
  assign digit    = ev.digit;
  assign op_in    = ev.op;
  assign op_code  = ev.op_code;
  assign sub_in   = ev.sub;
  assign ex_in    = ev.ex;
  assign bksp_in  = ev.bksp;
  assign reset_in = ev.clr;
  assign MS_in    = ev.ms;
  assign MR_in    = ev.mr;
  assign MC_in    = ev.mc;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x5 key matrix.
// Expected repeat count follows KEYPAD_REPEAT_EN.
module tb_keypad_scanner;

  localparam int SCAN = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row_n;
  logic [4:0]  col_n;
  logic        dig_in, op_in, sub_in, ex_in, bksp_in;
  logic        reset_in, MS_in, MR_in, MC_in;
  logic [3:0]  digit;
  logic [1:0]  op_code;
  logic [19:0] pressed = '0;

  int n_checks = 0;
  int n_fail = 0;
  int n_dig, n_op, n_sub, n_ex, n_bk, n_clr, n_ms, n_mr, n_mc;
  int last_digit, last_op, dig_cyc;
  int viol = 0;
  int cyc = 0;
  bit prev_any = 1'b0;

  // bits: dig op sub ex bksp clr ms mr mc
  logic [8:0] exp_mask [20] = '{
    9'h100, 9'h100, 9'h100, 9'h080, 9'h010,
    9'h100, 9'h100, 9'h100, 9'h080, 9'h008,
    9'h100, 9'h100, 9'h100, 9'h0C0, 9'h001,
    9'h100, 9'h004, 9'h002, 9'h080, 9'h020
  };
  int exp_val [20] = '{
    1, 2, 3, 0, 0,
    4, 5, 6, 2, 0,
    7, 8, 9, 1, 0,
    0, 0, 0, 3, 0
  };

  always #5 clock = ~clock;

  always_comb
    for (int r = 0; r < 4; r++)
      row_n[r] = ~|(pressed[r*5 +: 5] & ~col_n);

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_SCANS(4),
    .REPEAT_DELAY(5),
    .REPEAT_RATE(2)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .row_n   (row_n),
    .col_n   (col_n),
    .dig_in  (dig_in),
    .digit   (digit),
    .op_in   (op_in),
    .op_code (op_code),
    .sub_in  (sub_in),
    .ex_in   (ex_in),
    .bksp_in (bksp_in),
    .reset_in(reset_in),
    .MS_in   (MS_in),
    .MR_in   (MR_in),
    .MC_in   (MC_in)
  );

  always @(negedge clock) begin
    int evs;
    bit any;
    cyc++;
    if (!reset) begin
      if (dig_in) begin
        n_dig++;
        last_digit = int'(digit);
        dig_cyc = cyc;
      end
      if (op_in) begin
        n_op++;
        last_op = int'(op_code);
      end
      n_sub += int'(sub_in);
      n_ex  += int'(ex_in);
      n_bk  += int'(bksp_in);
      n_clr += int'(reset_in);
      n_ms  += int'(MS_in);
      n_mr  += int'(MR_in);
      n_mc  += int'(MC_in);
      if (!dig_in && digit != 4'd0) viol++;
      if (!op_in && op_code != 2'd0) viol++;
      if (sub_in && !(op_in && op_code == 2'b01)) viol++;
      evs = int'(dig_in) + int'(op_in) + int'(ex_in) + int'(bksp_in)
          + int'(reset_in) + int'(MS_in) + int'(MR_in) + int'(MC_in);
      if (evs > 1) viol++;
      any = (evs != 0) || sub_in;
      if (any && prev_any) viol++;
      prev_any = any;
    end
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_counts();
    n_dig = 0; n_op = 0; n_sub = 0; n_ex = 0; n_bk = 0;
    n_clr = 0; n_ms = 0; n_mr = 0; n_mc = 0;
    last_digit = -1; last_op = -1; dig_cyc = 0;
  endtask

  task automatic run_scans(input int n);
    repeat (n * SCAN) @(posedge clock);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_col"}, 64'(col_n), 64'(5'b11110));
    check({tag, "_outs"},
          64'({dig_in, digit, op_in, op_code, sub_in, ex_in,
               bksp_in, reset_in, MS_in, MR_in, MC_in}), 64'd0);
  endtask

  initial begin
    int press_cyc, lat, w;
    logic [35:0] got_v, exp_v;
    clr_counts();

    repeat (3) @(negedge clock);
    check_reset_outs("reset");
    reset = 1'b0;
    run_scans(2);

    // clean press of '5'
    clr_counts();
    @(negedge clock);
    press_cyc = cyc;
    pressed[6] = 1'b1;
    run_scans(6);
    pressed = '0;
    run_scans(6);
    check("k5_count", 64'(n_dig), 64'd1);
    check("k5_digit", 64'(last_digit), 64'd5);
    check("k5_no_op", 64'(n_op), 64'd0);
    lat = dig_cyc - press_cyc;
    check("k5_latency", 64'(lat >= 60 && lat <= 100), 64'd1);

    // minus with contact bounce
    clr_counts();
    @(negedge clock);
    repeat (3) begin
      pressed[13] = ~pressed[13];
      @(posedge clock);
    end
    pressed[13] = 1'b1;
    run_scans(10);
    check("minus_sub", 64'(n_sub), 64'd1);
    check("minus_op", 64'(n_op), 64'd1);
    check("minus_code", 64'(last_op), 64'd1);
    pressed = '0;
    run_scans(6);
    check("minus_no_extra", 64'(n_sub), 64'd1);
    pressed[13] = 1'b1;
    run_scans(6);
    check("minus_repress", 64'(n_sub), 64'd2);
    pressed = '0;
    run_scans(6);

    // 7 held, 8 rolled over
    clr_counts();
    pressed[10] = 1'b1;
    run_scans(6);
    pressed[11] = 1'b1;
    run_scans(4);
    pressed[10] = 1'b0;
    run_scans(8);
    check("roll_count", 64'(n_dig), 64'd1);
    check("roll_digit", 64'(last_digit), 64'd7);
    pressed[11] = 1'b0;
    run_scans(6);
    check("roll_rel8", 64'(n_dig), 64'd1);
    pressed[11] = 1'b1;
    run_scans(6);
    check("roll_press8", 64'(n_dig), 64'd2);
    check("roll_digit8", 64'(last_digit), 64'd8);
    pressed = '0;
    run_scans(6);

    // equals too short, then long enough
    clr_counts();
    @(negedge clock);
    pressed[19] = 1'b1;
    repeat (2 * SCAN) @(posedge clock);
    pressed = '0;
    run_scans(6);
    check("eq_short", 64'(n_ex), 64'd0);
    pressed[19] = 1'b1;
    run_scans(6);
    pressed = '0;
    run_scans(6);
    check("eq_long", 64'(n_ex), 64'd1);

    // reset while MR held
    clr_counts();
    pressed[17] = 1'b1;
    run_scans(6);
    check("mr_first", 64'(n_mr), 64'd1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_reset_outs("mr_rst0");
    repeat (2) @(negedge clock);
    check_reset_outs("mr_rst2");
    @(negedge clock);
    reset = 1'b0;
    run_scans(2);
    check("mr_no_early", 64'(n_mr), 64'd1);
    run_scans(6);
    check("mr_fresh", 64'(n_mr), 64'd2);
    pressed = '0;
    run_scans(6);
    check("mr_after_rel", 64'(n_mr), 64'd2);

    // backspace hold
    clr_counts();
    pressed[4] = 1'b1;
    w = 0;
    while (!bksp_in && w < 200) begin
      @(negedge clock);
      w++;
    end
    check("bksp_accept", 64'(bksp_in), 64'd1);
    repeat (12 * SCAN) @(posedge clock);
    pressed = '0;
    run_scans(6);
`ifdef KEYPAD_REPEAT_EN
    check("bksp_pulses", 64'(n_bk), 64'd5);
`else
    check("bksp_pulses", 64'(n_bk), 64'd1);
`endif
    check("bksp_no_digit", 64'(n_dig), 64'd0);

    // full key map
    for (int k = 0; k < 20; k++) begin
      clr_counts();
      pressed[k] = 1'b1;
      run_scans(6);
      pressed = '0;
      run_scans(6);
      got_v = {4'(n_dig), 4'(n_op), 4'(n_sub), 4'(n_ex), 4'(n_bk),
               4'(n_clr), 4'(n_ms), 4'(n_mr), 4'(n_mc)};
      exp_v = '0;
      for (int b = 0; b < 9; b++)
        exp_v[b*4] = exp_mask[k][b];
      check($sformatf("map%0d_strobes", k), 64'(got_v), 64'(exp_v));
      if (exp_mask[k][8])
        check($sformatf("map%0d_digit", k), 64'(last_digit),
              64'(exp_val[k]));
      if (exp_mask[k][7])
        check($sformatf("map%0d_opcode", k), 64'(last_op),
              64'(exp_val[k]));
    end

    check("pulse_rules", 64'(viol), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
